// File: rtl/conv_acc_pkg.sv
// Shared types and constants for the convolution accelerator control path.
package conv_acc_pkg;

   localparam int unsigned CFG_W        = 2;
   localparam int unsigned NTILE_W_DFLT = 6;
   localparam int unsigned CH_PER_GROUP = 8;

   typedef enum logic [2:0] {
      SCH_IDLE     = 3'd0,
      SCH_CFG      = 3'd1,
      SCH_WAIT_BUF = 3'd2,
      SCH_KICK     = 3'd3,
      SCH_RUN      = 3'd4,
      SCH_FLUSH    = 3'd5,
      SCH_WAIT_END = 3'd6,
      SCH_DONE     = 3'd7
   } sched_state_e;

   // Channel-group configuration forwarded to the PE array.
   typedef struct packed {
      logic [CFG_W-1:0] ci;
      logic [CFG_W-1:0] co;
   } chan_cfg_t;

   // Number of channels encoded by a group field: (n+1) groups of CH_PER_GROUP.
   function automatic int unsigned group_channels(input logic [CFG_W-1:0] grp);
      return (32'(grp) + 32'd1) * CH_PER_GROUP;
   endfunction

endpackage

// File: rtl/conv_sched_wdt.sv
// Watchdog cycle counter for the tile scheduler; expires after WDT_CYCLES enabled cycles.
module conv_sched_wdt #(
   parameter int unsigned WDT_CYCLES = 4096
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic expired_c
);

   localparam int unsigned CNT_W = $clog2(WDT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign expired_c = en && (cnt_q == CNT_W'(WDT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !expired_c) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/conv_tile_sched.sv
// Layer-level sequencer driving the PE array: config kick, per-tile kicks, flush, done.
// Optional watchdog enabled by defining CONV_TILE_SCHED_WDT_EN.
module conv_tile_sched
   import conv_acc_pkg::*;
#(
   parameter int unsigned NTILE_W    = NTILE_W_DFLT,
   parameter int unsigned WDT_CYCLES = 4096
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [CFG_W-1:0]   cmd_ci,
   input  logic [CFG_W-1:0]   cmd_co,
   input  logic [NTILE_W-1:0] cmd_ntile,
   input  logic               buf_ready,
   output logic               buf_release,
   input  logic               pe_busy,
   input  logic               pe_end,
   output logic               start_conv,
   output logic               start_again,
   output logic [CFG_W-1:0]   cfg_ci,
   output logic [CFG_W-1:0]   cfg_co,
   output logic [NTILE_W-1:0] tile_idx,
   output logic               busy,
   output logic               done,
   output logic               err
);

   if (WDT_CYCLES < 2) begin : g_wdt_range
      $error("WDT_CYCLES must be at least 2");
   end

   sched_state_e       state_q, state_d;
   chan_cfg_t          cfg_q, cfg_d;
   logic [NTILE_W-1:0] ntile_q, ntile_d;
   logic [NTILE_W-1:0] tile_idx_q, tile_idx_d;
   logic               seen_busy_q, seen_busy_d;
   logic               buf_release_q, buf_release_d;
   logic               tile_done_c;
   logic               last_tile_c;
   logic               wdt_exp_c;

   assign tile_done_c = seen_busy_q && !pe_busy;
   assign last_tile_c = (tile_idx_q == (ntile_q - NTILE_W'(1)));

`ifdef CONV_TILE_SCHED_WDT_EN
   logic err_q, err_d;
   logic wdt_en_c;
   logic state_chg_c;

   assign wdt_en_c    = (state_q == SCH_RUN) || (state_q == SCH_WAIT_END);
   assign state_chg_c = (state_d != state_q);
   assign err         = err_q;

   conv_sched_wdt #(
      .WDT_CYCLES (WDT_CYCLES)
   ) u_wdt (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (wdt_en_c),
      .clr       (state_chg_c),
      .expired_c (wdt_exp_c)
   );
`else
   assign wdt_exp_c = 1'b0;
   assign err       = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SCH_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         SCH_IDLE:     if (cmd_valid) state_d = SCH_CFG;
         SCH_CFG:      state_d = SCH_WAIT_BUF;
         SCH_WAIT_BUF: if (buf_ready) state_d = SCH_KICK;
         SCH_KICK:     state_d = SCH_RUN;
         SCH_RUN: begin
            if (wdt_exp_c) begin
               state_d = SCH_DONE;
            end else if (tile_done_c) begin
               state_d = last_tile_c ? SCH_FLUSH : SCH_WAIT_BUF;
            end
         end
         SCH_FLUSH:    state_d = SCH_WAIT_END;
         SCH_WAIT_END: if (wdt_exp_c || pe_end) state_d = SCH_DONE;
         SCH_DONE:     state_d = SCH_IDLE;
         default:      state_d = SCH_IDLE;
      endcase
   end

   // Output decode from the state register
   always_comb begin
      cmd_ready   = 1'b0;
      busy        = 1'b1;
      start_conv  = 1'b0;
      start_again = 1'b0;
      done        = 1'b0;
      case (state_q)
         SCH_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
         end
         SCH_CFG:              start_conv  = 1'b1;
         SCH_KICK, SCH_FLUSH:  start_again = 1'b1;
         SCH_DONE:             done        = 1'b1;
         default: ;
      endcase
   end

   // Datapath: config latch, tile counter, completion tracking
   always_comb begin
      cfg_d         = cfg_q;
      ntile_d       = ntile_q;
      tile_idx_d    = tile_idx_q;
      seen_busy_d   = seen_busy_q;
      buf_release_d = 1'b0;
`ifdef CONV_TILE_SCHED_WDT_EN
      err_d         = err_q;
      if ((state_q == SCH_IDLE) && cmd_valid) begin
         err_d = 1'b0;
      end else if (wdt_exp_c) begin
         err_d = 1'b1;
      end
`endif
      case (state_q)
         SCH_IDLE: begin
            if (cmd_valid) begin
               cfg_d.ci   = cmd_ci;
               cfg_d.co   = cmd_co;
               ntile_d    = (cmd_ntile == '0) ? NTILE_W'(1) : cmd_ntile;
               tile_idx_d = '0;
            end
         end
         SCH_KICK: seen_busy_d = 1'b0;
         SCH_RUN: begin
            if (pe_busy) seen_busy_d = 1'b1;
            if (!wdt_exp_c && tile_done_c) begin
               buf_release_d = 1'b1;
               if (!last_tile_c) tile_idx_d = tile_idx_q + NTILE_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_q         <= '0;
         ntile_q       <= '0;
         tile_idx_q    <= '0;
         seen_busy_q   <= 1'b0;
         buf_release_q <= 1'b0;
`ifdef CONV_TILE_SCHED_WDT_EN
         err_q         <= 1'b0;
`endif
      end else begin
         cfg_q         <= cfg_d;
         ntile_q       <= ntile_d;
         tile_idx_q    <= tile_idx_d;
         seen_busy_q   <= seen_busy_d;
         buf_release_q <= buf_release_d;
`ifdef CONV_TILE_SCHED_WDT_EN
         err_q         <= err_d;
`endif
      end
   end

   assign cfg_ci      = cfg_q.ci;
   assign cfg_co      = cfg_q.co;
   assign tile_idx    = tile_idx_q;
   assign buf_release = buf_release_q;

endmodule

// File: doc/conv_tile_sched.md
Name: conv_tile_sched

Overview:
- Layer-level sequencer that drives the PE array control FSM for one convolution layer.
- Accepts a host command (valid/ready) and forwards channel config. Pulses start_conv once, then issues one start_again per output tile, gated on the input/weight buffers being loaded.
- Detects tile completion from the PE's ifm_read activity, releases buffers, and issues a final flush start_again. Waits for end_conv, then reports done.
- Sits between the host/DMA control and the PE FSM.

Parameters:
- NTILE_W, 6: width of the tile-count field.
- WDT_CYCLES, 4096: watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  scheduler can accept a command
- cmd_ci  in  2  input-channel group config, (n+1)*8 channels
- cmd_co  in  2  output-channel group config
- cmd_ntile  in  NTILE_W  number of output tiles in the layer
- buf_ready  in  1  IFM/WGT buffers hold data for the next tile
- buf_release  out  1  1-cycle pulse: current tile consumed, buffers may refill
- pe_busy  in  1  PE ifm_read
- pe_end  in  1  PE end_conv
- start_conv  out  1  1-cycle config-latch pulse to PE
- start_again  out  1  1-cycle tile/flush kick to PE
- cfg_ci  out  2  held copy of cmd_ci
- cfg_co  out  2  held copy of cmd_co
- tile_idx  out  NTILE_W  index of the tile in flight
- busy  out  1  high in every state except IDLE
- done  out  1  1-cycle pulse when the layer finishes
- err  out  1  sticky watchdog error

Behaviour:
- All outputs are registered or decoded from the state register. No combinational path from any input to any output.
- Reset values: state IDLE; cmd_ready 1; every other output 0, including cfg_*, tile_idx and all counters.
- States: IDLE, CFG, WAIT_BUF, KICK, RUN, FLUSH, WAIT_END, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready: latch cmd_ci/cmd_co into cfg_ci/cfg_co and ntile = max(cmd_ntile, 1); clear tile_idx; go to CFG.
- CFG: start_conv = 1 for exactly one cycle; go to WAIT_BUF.
- WAIT_BUF: stay until buf_ready = 1, then go to KICK. buf_ready is only sampled in this state.
- KICK:
  - start_again = 1 for one cycle.
  - Clear seen_busy and go to RUN.
  - Latency: buf_ready high at edge N gives start_again high in cycle N+1.
- RUN:
  - Set seen_busy when pe_busy = 1.
  - Tile is complete at the first cycle with seen_busy = 1 and pe_busy = 0. On completion, buf_release pulses 1 cycle.
  - If tile_idx == ntile-1, go to FLUSH. Otherwise tile_idx += 1 and go to WAIT_BUF.
- FLUSH: start_again = 1 for one cycle (terminating kick); go to WAIT_END.
- WAIT_END: on pe_end = 1, go to DONE.
- DONE: done = 1 for one cycle; go to IDLE. cmd_ready is high the following cycle.
- pe_end outside WAIT_END is ignored.
- cmd_valid while busy is not accepted (cmd_ready = 0). Command fields are ignored outside the handshake.
- cfg_ci/cfg_co hold their latched values until the next accepted command.
- Reset mid-operation returns to IDLE immediately. No pulses are emitted during reset.
- err is cleared only on an accepted command or on reset.

Optional Feature:
- Macro CONV_TILE_SCHED_WDT_EN, defined:
  - A watchdog counter runs in RUN and WAIT_END and clears on every state change.
  - On reaching WDT_CYCLES: set err, pulse done, return to IDLE.
- Undefined: err is tied 0; no counter logic is built.

Decomposition:
- Shared package conv_acc_pkg:
  - state encoding typedef for the scheduler;
  - CFG_W = 2;
  - NTILE_W default;
  - CH_PER_GROUP = 8.
- Sub-module conv_sched_wdt: the watchdog counter, instantiated only under the macro.
- Everything else stays in one module.

Test Plan:
- Reset mid-RUN: assert rst_n = 0 -> state IDLE, all pulses 0, cmd_ready = 1, cfg_ci = cfg_co = 0.
- Normal layer: cmd ci = 1, co = 2, ntile = 3; buf_ready always 1; PE model holds pe_busy for 30 cycles per tile ->
  - 1 start_conv, then 3 start_again and 3 buf_release, then 1 flush start_again;
  - after pe_end, done pulses once;
  - tile_idx steps 0, 1, 2.
- Buffer stall: buf_ready held 0 for 50 cycles before tile 1 -> no start_again in that window; start_again exactly 1 cycle after buf_ready rises.
- Edge cases:
  - cmd_ntile = 0 behaves as 1 tile: 2 start_again total.
  - cmd_valid asserted during RUN is not accepted, and cfg outputs are unchanged.
- With CONV_TILE_SCHED_WDT_EN and WDT_CYCLES = 64: pe_busy never rises -> err = 1 and a done pulse at 64 cycles after KICK, then IDLE; next command clears err.
